led_flash_ctrl: RTL and testbench

Downstream consumer of the key-press LED control FSM. Accepts a flash request (en, mode, times), drives the board LEDs through `times` on/off flashes in one of two patterns, then returns a one-cycle flash_done pulse. It also re-arms safely against the upstream FSM, which holds en high until it has sampled flash_done.

---
 rtl/led_pkg.sv | 18 +
 rtl/led_phase_timer.sv | 30 +++
 rtl/led_flash_ctrl.sv | 150 +++++++++++++++
 tb/tb_led_flash_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED flash controller.
package led_pkg;

  localparam int unsigned TIMES_W             = 6;
  localparam int unsigned HALF_PERIOD_DEFAULT = 12_500_000;  // 0.25 s at 50 MHz

  localparam logic MODE_BLINK = 1'b0;
  localparam logic MODE_RUN   = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StOn,
    StOff,
    StDone,
    StWaitLow
  } led_state_e;

endpackage

// File: rtl/led_phase_timer.sv
// Phase counter shared by the ON and OFF phases; wraps to zero at terminal count.
module led_phase_timer #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned CNT_W       = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TcVal = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tc = (cnt_q == TcVal);

  // Clear has priority; an enabled count restarts from zero after terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/led_flash_ctrl.sv
// Flashes the LEDs a requested number of times, then pulses flash_done once.
module led_flash_ctrl
  import led_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEFAULT,
  parameter int unsigned LED_W       = 4,
  parameter int unsigned CNT_W       = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [TIMES_W-1:0] times,
  output logic               flash_done,
  output logic [LED_W-1:0]   led,
  output logic               busy
);

  localparam int unsigned      PosW   = (LED_W > 1) ? $clog2(LED_W) : 1;
  localparam logic [PosW-1:0]  PosMax = PosW'(LED_W - 1);
  localparam logic [LED_W-1:0] LedOne = LED_W'(1);

  led_state_e         state_q, state_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               flash_done_q, flash_done_d;
  logic [TIMES_W-1:0] remain_q, remain_d;
  logic [PosW-1:0]    pos_q, pos_d;
  logic               mode_q, mode_d;
  logic [PosW-1:0]    pos_next;
  logic               timer_clr, timer_en, phase_tc;

  function automatic logic [LED_W-1:0] on_pattern(input logic m, input logic [PosW-1:0] p);
    return (m == MODE_RUN) ? (LedOne << p) : {LED_W{1'b1}};
  endfunction

  assign pos_next = (pos_q == PosMax) ? '0 : pos_q + 1'b1;

  led_phase_timer #(
    .HALF_PERIOD (HALF_PERIOD),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .tc    (phase_tc)
  );

  // Next-state, LED pattern and done-pulse decode.
  always_comb begin
    state_d      = state_q;
    led_d        = led_q;
    flash_done_d = 1'b0;
    remain_d     = remain_q;
    pos_d        = pos_q;
    mode_d       = mode_q;
    timer_clr    = 1'b0;
    timer_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        timer_clr = 1'b1;
        led_d     = '0;
        if (en) begin
          mode_d   = mode;
          remain_d = times;
          if (times == '0) begin
            state_d = StDone;
          end else begin
            state_d = StOn;
            led_d   = on_pattern(mode, pos_q);
          end
        end
      end
      StOn: begin
        if (!en) begin
          timer_clr = 1'b1;
          led_d     = '0;
          state_d   = StIdle;
        end else begin
          timer_en = 1'b1;
          if (phase_tc) begin
            led_d   = '0;
            state_d = StOff;
          end
        end
      end
      StOff: begin
        if (!en) begin
          timer_clr = 1'b1;
          led_d     = '0;
          state_d   = StIdle;
        end else begin
          timer_en = 1'b1;
          if (phase_tc) begin
            remain_d = remain_q - 1'b1;
            pos_d    = pos_next;
            if (remain_q == TIMES_W'(1)) begin
              flash_done_d = 1'b1;
              state_d      = StDone;
            end else begin
              led_d   = on_pattern(mode_q, pos_next);
              state_d = StOn;
            end
          end
        end
      end
      StDone: begin
        // A zero-count request enters without a pulse, so it pulses on the way out.
        timer_clr    = 1'b1;
        flash_done_d = ~flash_done_q;
        state_d      = StWaitLow;
      end
      StWaitLow: begin
        timer_clr = 1'b1;
        if (!en) begin
          state_d = StIdle;
        end
      end
      default: begin
        timer_clr = 1'b1;
        led_d     = '0;
        state_d   = StIdle;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      led_q        <= '0;
      flash_done_q <= 1'b0;
      remain_q     <= '0;
      pos_q        <= '0;
      mode_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      led_q        <= led_d;
      flash_done_q <= flash_done_d;
      remain_q     <= remain_d;
      pos_q        <= pos_d;
      mode_q       <= mode_d;
    end
  end

  assign led        = led_q;
  assign flash_done = flash_done_q;
  assign busy       = (state_q == StOn) || (state_q == StOff) || (state_q == StDone);

endmodule

// File: tb/tb_led_flash_ctrl.sv
// Scoreboard bench: requests push expected LED changes and done pulses with their cycle.
module tb_led_flash_ctrl;

  localparam int HP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [5:0] times = '0;
  logic       flash_done;
  logic [3:0] led;
  logic       busy;

  typedef struct {
    bit         is_done;
    logic [3:0] val;
    int         cyc;
  } ev_t;

  ev_t        sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         fails = 0;
  int         pos_m = 0;
  logic [3:0] prev_led = '0;

  led_flash_ctrl #(
    .HALF_PERIOD (HP),
    .LED_W       (4),
    .CNT_W       (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .times      (times),
    .flash_done (flash_done),
    .led        (led),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit d, input logic [3:0] v, input int c);
    ev_t e;
    e.is_done = d;
    e.val     = v;
    e.cyc     = c;
    sb.push_back(e);
  endtask

  task automatic observe(input bit d, input logic [3:0] v);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected_%s: got val=%b at cycle %0d, expected no event",
               d ? "done" : "led", v, cyc);
    end else begin
      e = sb.pop_front();
      if (e.is_done != d || e.val !== v || e.cyc != cyc) begin
        fails++;
        $display("FAIL event: got done=%0d led=%b cycle=%0d, expected done=%0d led=%b cycle=%0d",
                 d, v, cyc, e.is_done, e.val, e.cyc);
      end
    end
  endtask

  // Monitor: every LED change and every flash_done cycle is an observed event.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_led <= '0;
    end else begin
      if (led !== prev_led) observe(1'b0, led);
      if (flash_done === 1'b1) observe(1'b1, 4'b0000);
      prev_led <= led;
    end
  end

  function automatic logic [3:0] exp_pat(input bit m, input int p);
    logic [3:0] one;
    one = 4'b0001;
    return m ? (one << p) : 4'b1111;
  endfunction

  task automatic wait_scramble(input int t);
    while (cyc < t) begin
      @(negedge clk);
      mode  = 1'($urandom_range(0, 1));
      times = 6'($urandom_range(0, 63));
    end
  endtask

  // One request: n flashes; abort_off>0 drops en so edge e0+abort_off sees it low.
  task automatic run_req(input bit m, input int n, input int abort_off, input int hold);
    int e0, ca, d, k;
    @(negedge clk);
    en    = 1'b1;
    mode  = m;
    times = 6'(n);
    e0    = cyc + 1;
    ca    = (abort_off > 0) ? e0 + abort_off : 32'h7fff_ffff;
    for (k = 0; k < n; k++) begin
      if (e0 + 2 * k * HP < ca) push(1'b0, exp_pat(m, (pos_m + k) % 4), e0 + 2 * k * HP);
      if (e0 + (2 * k + 1) * HP < ca) push(1'b0, 4'b0000, e0 + (2 * k + 1) * HP);
    end
    if (abort_off > 0) begin
      if (((ca - 1 - e0) / HP) % 2 == 0) push(1'b0, 4'b0000, ca);
      pos_m = (pos_m + (ca - 1 - e0) / (2 * HP)) % 4;
      d = 0;
    end else begin
      d = (n > 0) ? e0 + 2 * n * HP : e0 + 1;
      push(1'b1, 4'b0000, d);
      pos_m = (pos_m + n) % 4;
    end
    while (cyc < e0) @(negedge clk);
    check("busy_after_start", int'(busy), 1);
    if (abort_off > 0) begin
      wait_scramble(ca - 1);
      en = 1'b0;
      @(negedge clk);
      check("busy_after_abort", int'(busy), 0);
      check("led_after_abort", int'(led), 0);
    end else begin
      wait_scramble(d + 1 + hold);
      check("busy_wait_low", int'(busy), 0);
      en = 1'b0;
    end
  endtask

  initial begin
    int e0;
    #1;
    check("reset_led", int'(led), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(flash_done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_req(1'b1, 5, 0, 0);   // running light with wrap
    run_req(1'b1, 1, 0, 0);   // continues from last position
    run_req(1'b0, 3, 0, 0);   // blink together
    run_req(1'b0, 0, 0, 4);   // zero count, en held in WAIT_LOW
    run_req(1'b0, 20, 4 * HP + 2, 0);  // abort in third ON phase
    run_req(1'b1, 2, 0, 0);   // clean start after abort

    // Asynchronous reset in the second OFF phase.
    @(negedge clk);
    en    = 1'b1;
    mode  = 1'b1;
    times = 6'd3;
    e0    = cyc + 1;
    push(1'b0, exp_pat(1'b1, pos_m), e0);
    push(1'b0, 4'b0000, e0 + HP);
    push(1'b0, exp_pat(1'b1, (pos_m + 1) % 4), e0 + 2 * HP);
    push(1'b0, 4'b0000, e0 + 3 * HP);
    while (cyc < e0 + 3 * HP + 1) @(negedge clk);
    check("busy_before_reset", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_led", int'(led), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_done", int'(flash_done), 0);
    check("queue_drained_before_reset", sb.size(), 0);
    sb.delete();
    pos_m = 0;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_req(1'b1, 2, 0, 0);

    // Back-to-back: new mode/times latched on re-raise.
    run_req(1'b0, 2, 0, 0);
    run_req(1'b1, 2, 0, 0);

    for (int i = 0; i < 25; i++) begin
      int n, ab;
      n  = $urandom_range(0, 6);
      ab = 0;
      if (n > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, 2 * n * HP - 1);
      run_req(1'($urandom_range(0, 1)), n, ab, $urandom_range(0, 2));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
